// File: rtl/banked_regfile_tally.sv
// banked_regfile_tally
//
// Banked register file with a tally/mode engine and a hardware clear sequencer.
//
// Register file: NUM_BANKS x 8 registers, flat address {bank, reg}. Flat 0 always
// reads 0 and ignores writes. Flat 8 is the setting register. Its fields select
// the bank used by short addresses:
//   [BW-1:0] read port 1, [2BW-1:BW] read port 2, [3BW-1:2BW] write port.
// Reads are combinational. Writes happen on the rising clock edge.
//
// Tally engine: S0 registers an accepted sample. S1 increments the bin count
// (saturating) and updates the running mode. A lower value wins a tie.
// The clear FSM (StClear) zeroes one bin per cycle after reset or after
// tally_clr_i. While it runs, tally_ready_o is held low.
//
// Optional feature: define REGFILE_BYPASS_EN to forward wr_data_i to a read
// whose flat address matches the write target in the same cycle. Flat 0 is never
// forwarded.
//
// Ports:
//   clk_i, rst_i                  clock, asynchronous active-high reset
//   rd_addr1_i, rd_addr2_i        short read addresses (banked)
//   rd_full_en_i, rd_full_addr_i  port 1 flat-address override
//   rd_data1_o, rd_data2_o        read data
//   we_i, wr_addr_i, wr_full_en_i, wr_full_addr_i, wr_data_i  write port
//   setting_o                     current setting register
//   tally_valid_i, tally_value_i, tally_ready_o  tally sample handshake
//   tally_clr_i                   clear request
//   mode_value_o, mode_count_o    most frequent value and its count
module banked_regfile_tally #(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned NUM_BANKS   = 2,
  parameter int unsigned TALLY_DEPTH = 64,
  parameter int unsigned CNT_W       = 8,
  localparam int unsigned BW    = $clog2(NUM_BANKS),
  localparam int unsigned TW    = $clog2(TALLY_DEPTH),
  localparam int unsigned AW    = 3 + BW,
  localparam int unsigned NREGS = NUM_BANKS * 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [2:0]        rd_addr1_i,
  input  logic [2:0]        rd_addr2_i,
  input  logic              rd_full_en_i,
  input  logic [AW-1:0]     rd_full_addr_i,
  output logic [DATA_W-1:0] rd_data1_o,
  output logic [DATA_W-1:0] rd_data2_o,
  input  logic              we_i,
  input  logic [2:0]        wr_addr_i,
  input  logic              wr_full_en_i,
  input  logic [AW-1:0]     wr_full_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  output logic [DATA_W-1:0] setting_o,
  input  logic              tally_valid_i,
  input  logic [DATA_W-1:0] tally_value_i,
  output logic              tally_ready_o,
  input  logic              tally_clr_i,
  output logic [DATA_W-1:0] mode_value_o,
  output logic [CNT_W-1:0]  mode_count_o
);

  // ---------------------------------------------------------------------------
  // Register file
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] regs_q [NREGS];

  logic [BW-1:0] rd1_bank, rd2_bank, wr_bank;
  logic [AW-1:0] rd1_flat, rd2_flat, wr_flat;
  logic          wr_hit;

  assign setting_o = regs_q[8];
  assign rd1_bank  = setting_o[BW-1:0];
  assign rd2_bank  = setting_o[2*BW-1:BW];
  assign wr_bank   = setting_o[3*BW-1:2*BW];

  always_comb begin
    rd1_flat = rd_full_en_i ? rd_full_addr_i : {rd1_bank, rd_addr1_i};
    rd2_flat = {rd2_bank, rd_addr2_i};
    wr_flat  = wr_full_en_i ? wr_full_addr_i : {wr_bank, wr_addr_i};
    wr_hit   = we_i && (wr_flat != '0);
  end

  always_comb begin
    rd_data1_o = (rd1_flat == '0) ? '0 : regs_q[rd1_flat];
    rd_data2_o = (rd2_flat == '0) ? '0 : regs_q[rd2_flat];
`ifdef REGFILE_BYPASS_EN
    // wr_hit already excludes flat 0, so flat 0 is never forwarded.
    if (wr_hit && (rd1_flat == wr_flat)) rd_data1_o = wr_data_i;
    if (wr_hit && (rd2_flat == wr_flat)) rd_data2_o = wr_data_i;
`endif
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(NREGS); i++) regs_q[i] <= '0;
    end else if (wr_hit) begin
      regs_q[wr_flat] <= wr_data_i;
    end
  end

  // ---------------------------------------------------------------------------
  // Clear FSM
  // ---------------------------------------------------------------------------
  typedef enum logic [0:0] {StIdle, StClear} state_e;

  state_e        state_q, state_d;
  logic [TW-1:0] clr_idx_q, clr_idx_d;
  logic          clr_start;
  logic          clr_active;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= StClear;
      clr_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    unique case (state_q)
      StIdle: begin
        clr_idx_d = '0;
        if (tally_clr_i) state_d = StClear;
      end
      StClear: begin
        clr_idx_d = clr_idx_q + TW'(1);
        if (clr_idx_q == TW'(TALLY_DEPTH - 1)) state_d = StIdle;
      end
      default: state_d = StClear;
    endcase
  end

  always_comb begin
    tally_ready_o = (state_q == StIdle);
    clr_start     = (state_q == StIdle) && tally_clr_i;
    clr_active    = (state_q == StClear);
  end

  // ---------------------------------------------------------------------------
  // Tally pipeline
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0]  cnt_q [TALLY_DEPTH];
  logic              s1_valid_q;
  logic [TW-1:0]     s1_bin_q;
  logic [DATA_W-1:0] s1_value_q;
  logic [DATA_W-1:0] mode_value_q, mode_value_d;
  logic [CNT_W-1:0]  mode_count_q, mode_count_d;

  logic             accept;
  logic             s1_commit;
  logic [CNT_W-1:0] cur_cnt, new_cnt;
  logic             mode_win;

  // A clear request takes priority over a sample offered in the same cycle.
  assign accept    = tally_valid_i && tally_ready_o && !tally_clr_i;
  assign s1_commit = s1_valid_q && !clr_start;

  // The count array is read combinationally. A write from the previous S1 is
  // already visible here, so back-to-back samples to one bin lose no increment.
  always_comb begin
    cur_cnt  = cnt_q[s1_bin_q];
    new_cnt  = (cur_cnt == '1) ? cur_cnt : cur_cnt + CNT_W'(1);
    mode_win = (new_cnt > mode_count_q) ||
               ((new_cnt == mode_count_q) && (s1_value_q < mode_value_q));
  end

  always_comb begin
    mode_value_d = mode_value_q;
    mode_count_d = mode_count_q;
    if (clr_start) begin
      mode_value_d = '0;
      mode_count_d = '0;
    end else if (s1_commit && mode_win) begin
      mode_value_d = s1_value_q;
      mode_count_d = new_cnt;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_valid_q   <= 1'b0;
      s1_bin_q     <= '0;
      s1_value_q   <= '0;
      mode_value_q <= '0;
      mode_count_q <= '0;
    end else begin
      s1_valid_q   <= accept;
      if (accept) begin
        s1_bin_q   <= tally_value_i[TW-1:0];
        s1_value_q <= tally_value_i;
      end
      mode_value_q <= mode_value_d;
      mode_count_q <= mode_count_d;
    end
  end

  // The count memory has no reset. The clear sequencer walks it after every reset.
  always_ff @(posedge clk_i) begin
    if (clr_active) begin
      cnt_q[clr_idx_q] <= '0;
    end else if (s1_commit) begin
      cnt_q[s1_bin_q] <= new_cnt;
    end
  end

  assign mode_value_o = mode_value_q;
  assign mode_count_o = mode_count_q;

endmodule

// File: tb/tb_banked_regfile_tally.sv
// Directed testbench for banked_regfile_tally: an 8-bit-count instance and a
// 2-bit-count instance share the same stimulus.
module tb_banked_regfile_tally;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic [2:0] rd_addr1_i, rd_addr2_i;
  logic       rd_full_en_i;
  logic [3:0] rd_full_addr_i;
  logic [7:0] rd_data1_o, rd_data2_o;
  logic       we_i;
  logic [2:0] wr_addr_i;
  logic       wr_full_en_i;
  logic [3:0] wr_full_addr_i;
  logic [7:0] wr_data_i;
  logic [7:0] setting_o;
  logic       tally_valid_i;
  logic [7:0] tally_value_i;
  logic       tally_ready_o;
  logic       tally_clr_i;
  logic [7:0] mode_value_o;
  logic [7:0] mode_count_o;

  logic [7:0] rd_data1_s, rd_data2_s, setting_s, mode_value_s;
  logic       tally_ready_s;
  logic [1:0] mode_count_s;

  int total = 0;
  int bad   = 0;

  always #5 clk_i = ~clk_i;

  banked_regfile_tally #(.DATA_W(8), .NUM_BANKS(2), .TALLY_DEPTH(64), .CNT_W(8)) u_dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .rd_addr1_i     (rd_addr1_i),
    .rd_addr2_i     (rd_addr2_i),
    .rd_full_en_i   (rd_full_en_i),
    .rd_full_addr_i (rd_full_addr_i),
    .rd_data1_o     (rd_data1_o),
    .rd_data2_o     (rd_data2_o),
    .we_i           (we_i),
    .wr_addr_i      (wr_addr_i),
    .wr_full_en_i   (wr_full_en_i),
    .wr_full_addr_i (wr_full_addr_i),
    .wr_data_i      (wr_data_i),
    .setting_o      (setting_o),
    .tally_valid_i  (tally_valid_i),
    .tally_value_i  (tally_value_i),
    .tally_ready_o  (tally_ready_o),
    .tally_clr_i    (tally_clr_i),
    .mode_value_o   (mode_value_o),
    .mode_count_o   (mode_count_o)
  );

  banked_regfile_tally #(.DATA_W(8), .NUM_BANKS(2), .TALLY_DEPTH(64), .CNT_W(2)) u_dut_sat (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .rd_addr1_i     (rd_addr1_i),
    .rd_addr2_i     (rd_addr2_i),
    .rd_full_en_i   (rd_full_en_i),
    .rd_full_addr_i (rd_full_addr_i),
    .rd_data1_o     (rd_data1_s),
    .rd_data2_o     (rd_data2_s),
    .we_i           (we_i),
    .wr_addr_i      (wr_addr_i),
    .wr_full_en_i   (wr_full_en_i),
    .wr_full_addr_i (wr_full_addr_i),
    .wr_data_i      (wr_data_i),
    .setting_o      (setting_s),
    .tally_valid_i  (tally_valid_i),
    .tally_value_i  (tally_value_i),
    .tally_ready_o  (tally_ready_s),
    .tally_clr_i    (tally_clr_i),
    .mode_value_o   (mode_value_s),
    .mode_count_o   (mode_count_s)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Counts the negedges on which ready is low, with a bound of 200 cycles.
  task automatic wait_ready(input string tag);
    int n = 0;
    while (!tally_ready_o && n < 200) begin
      n++;
      @(negedge clk_i);
    end
    check(tag, n, 64);
  endtask

  task automatic wr_full(input logic [3:0] addr, input logic [7:0] data);
    we_i = 1'b1; wr_full_en_i = 1'b1; wr_full_addr_i = addr; wr_data_i = data;
    @(negedge clk_i);
    we_i = 1'b0; wr_full_en_i = 1'b0;
  endtask

  task automatic wr_short(input logic [2:0] addr, input logic [7:0] data);
    we_i = 1'b1; wr_full_en_i = 1'b0; wr_addr_i = addr; wr_data_i = data;
    @(negedge clk_i);
    we_i = 1'b0;
  endtask

  task automatic tally_clear();
    tally_clr_i = 1'b1;
    @(negedge clk_i);
    tally_clr_i = 1'b0;
    wait_ready("clr_ready_low");
  endtask

  // Back-to-back stream. The result for sample k is visible two negedges after it is driven.
  task automatic run_stream(input logic [7:0] vals[$], input logic [7:0] ev[$],
                            input logic [7:0] ec[$], input logic [7:0] ev2[$],
                            input logic [7:0] ec2[$]);
    for (int k = 0; k < vals.size() + 2; k++) begin
      if (k < vals.size()) begin
        tally_valid_i = 1'b1;
        tally_value_i = vals[k];
        #1 check("stream_ready", tally_ready_o, 1);
      end else begin
        tally_valid_i = 1'b0;
      end
      if (k >= 2) begin
        check("mode_value", mode_value_o, ev[k-2]);
        check("mode_count", mode_count_o, ec[k-2]);
        check("sat_mode_value", mode_value_s, ev2[k-2]);
        check("sat_mode_count", mode_count_s, ec2[k-2]);
      end
      @(negedge clk_i);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] q_v[$], q_ev[$], q_ec[$], q_ev2[$], q_ec2[$];
    rst_i = 1'b1;
    rd_addr1_i = 3'd0; rd_addr2_i = 3'd0; rd_full_en_i = 1'b0; rd_full_addr_i = 4'd0;
    we_i = 1'b0; wr_addr_i = 3'd0; wr_full_en_i = 1'b0; wr_full_addr_i = 4'd0;
    wr_data_i = 8'd0; tally_valid_i = 1'b1; tally_value_i = 8'd5; tally_clr_i = 1'b0;

    // Reset state
    repeat (3) @(negedge clk_i);
    check("rst_ready", tally_ready_o, 0);
    check("rst_rd1", rd_data1_o, 0);
    check("rst_rd2", rd_data2_o, 0);
    check("rst_setting", setting_o, 0);
    check("rst_mode_value", mode_value_o, 0);
    check("rst_mode_count", mode_count_o, 0);
    rst_i = 1'b0;
    #1 wait_ready("rst_ready_low");
    tally_valid_i = 1'b0;

    // Register file and bank mapping
    wr_full(4'd9, 8'h5A);
    wr_short(3'd1, 8'h11);
    wr_short(3'd4, 8'h12);
    rd_addr1_i = 3'd1; rd_addr2_i = 3'd1;
    we_i = 1'b1; wr_full_en_i = 1'b1; wr_full_addr_i = 4'd8; wr_data_i = 8'h01;
    #1 check("setting_old_map", rd_data1_o, 8'h11);
    @(negedge clk_i);
    we_i = 1'b0; wr_full_en_i = 1'b0;
    #1 check("bank1_rd1", rd_data1_o, 8'h5A);
    check("bank0_rd2", rd_data2_o, 8'h11);
    check("setting_01", setting_o, 8'h01);
    wr_full(4'd8, 8'h02);
    #1 check("bank0_rd1", rd_data1_o, 8'h11);
    check("bank1_rd2", rd_data2_o, 8'h5A);
    wr_full(4'd0, 8'hFF);
    rd_full_en_i = 1'b1; rd_full_addr_i = 4'd0;
    #1 check("flat0_zero", rd_data1_o, 0);
    wr_full(4'd8, 8'h04);
    wr_short(3'd2, 8'h77);
    rd_full_addr_i = 4'd10;
    #1 check("wr_bank1", rd_data1_o, 8'h77);
    rd_full_addr_i = 4'd2;
    #1 check("wr_bank0_untouched", rd_data1_o, 0);
    rd_full_en_i = 1'b0;
    wr_full(4'd8, 8'h00);

    // Same-cycle write/read of reg 4
    rd_addr1_i = 3'd4;
    we_i = 1'b1; wr_addr_i = 3'd4; wr_data_i = 8'h33;
`ifdef REGFILE_BYPASS_EN
    #1 check("same_cycle_rd", rd_data1_o, 8'h33);
`else
    #1 check("same_cycle_rd", rd_data1_o, 8'h12);
`endif
    @(negedge clk_i);
    we_i = 1'b0;
    #1 check("after_write_rd", rd_data1_o, 8'h33);
    rd_full_en_i = 1'b1; rd_full_addr_i = 4'd0;
    we_i = 1'b1; wr_full_en_i = 1'b1; wr_full_addr_i = 4'd0; wr_data_i = 8'hFF;
    #1 check("flat0_no_bypass", rd_data1_o, 0);
    @(negedge clk_i);
    we_i = 1'b0; wr_full_en_i = 1'b0; rd_full_en_i = 1'b0;

    // Tally stream 5,5,3,3,3
    q_v = '{8'd5, 8'd5, 8'd3, 8'd3, 8'd3};
    q_ev = '{8'd5, 8'd5, 8'd5, 8'd3, 8'd3};
    q_ec = '{8'd1, 8'd2, 8'd2, 8'd2, 8'd3};
    run_stream(q_v, q_ev, q_ec, q_ev, q_ec);

    // Clear together with a valid sample: the sample is dropped
    tally_clr_i = 1'b1; tally_valid_i = 1'b1; tally_value_i = 8'd9;
    @(negedge clk_i);
    tally_clr_i = 1'b0; tally_valid_i = 1'b0;
    #1 check("clr_mode_value", mode_value_o, 0);
    check("clr_mode_count", mode_count_o, 0);
    wait_ready("clr_valid_ready_low");
    q_v = '{8'd9, 8'd3};
    q_ev = '{8'd9, 8'd3};
    q_ec = '{8'd1, 8'd1};
    run_stream(q_v, q_ev, q_ec, q_ev, q_ec);

    // Saturation: 7 six times, then 2 three times
    tally_clear();
    q_v   = '{8'd7, 8'd7, 8'd7, 8'd7, 8'd7, 8'd7, 8'd2, 8'd2, 8'd2};
    q_ev  = '{8'd7, 8'd7, 8'd7, 8'd7, 8'd7, 8'd7, 8'd7, 8'd7, 8'd7};
    q_ec  = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd6, 8'd6, 8'd6};
    q_ev2 = '{8'd7, 8'd7, 8'd7, 8'd7, 8'd7, 8'd7, 8'd7, 8'd7, 8'd2};
    q_ec2 = '{8'd1, 8'd2, 8'd3, 8'd3, 8'd3, 8'd3, 8'd3, 8'd3, 8'd3};
    run_stream(q_v, q_ev, q_ec, q_ev2, q_ec2);

    // Reset while a sample is in flight
    rd_addr1_i = 3'd1;
    tally_valid_i = 1'b1; tally_value_i = 8'd7;
    @(negedge clk_i);
    rst_i = 1'b1;
    #1 check("midrst_mode_value", mode_value_o, 0);
    check("midrst_mode_count", mode_count_o, 0);
    check("midrst_ready", tally_ready_o, 0);
    check("midrst_rd1", rd_data1_o, 0);
    @(negedge clk_i);
    rst_i = 1'b0; tally_valid_i = 1'b0;
    #1 wait_ready("midrst_ready_low");
    q_v = '{8'd7};
    q_ev = '{8'd7};
    q_ec = '{8'd1};
    run_stream(q_v, q_ev, q_ec, q_ev, q_ec);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
